// File: rtl/sig_sync_ctrl.sv
// rtl/sig_sync_ctrl.sv - resync sequencing, preamble hunt and lock supervision for sig_sync
module sig_sync_ctrl #(
  parameter int               PULSE_LEN    = 4,
  parameter int               SETTLE_LEN   = 32,
  parameter int               PRE_W        = 16,
  parameter logic [PRE_W-1:0] PREAMBLE     = 16'hA5F0,
  parameter int               HUNT_TIMEOUT = 4096,
  parameter int               MAX_RETRY    = 3,
  parameter int               MAX_RUN      = 1024,
  parameter int               CNT_W        = 16
) (
  input  logic       AXI_clk,
  input  logic       AXI_rst,
  input  logic       start,
  input  logic       abort,
  input  logic       auto_en,
  input  logic       sig_out,
  output logic       resyncn,
  output logic       busy,
  output logic       locked,
  output logic       fail,
  output logic       lost,
  output logic [3:0] retry_cnt
);

  localparam int VAL_W = $clog2(PRE_W + 1);

  // The phase timer counts cycles already spent, so a phase ends when it shows LEN-1.
  localparam logic [CNT_W-1:0] PULSE_END  = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_LEN - 1);
  localparam logic [CNT_W-1:0] HUNT_END   = CNT_W'(HUNT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RUN_MAX    = CNT_W'(MAX_RUN);
  localparam logic [VAL_W-1:0] VAL_FULL   = VAL_W'(PRE_W);
  localparam logic [3:0]       RETRY_LIM  = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PULSE, ST_SETTLE, ST_HUNT, ST_LOCKED, ST_FAIL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q;
  logic [CNT_W-1:0] run_q, run_d;
  logic [PRE_W-1:0] shift_q, shift_d;
  logic [VAL_W-1:0] valid_q, valid_d;
  logic             prev_q;
  logic [3:0]       retry_q, retry_d;
  logic             lost_q, lost_d;
  logic             match, run_hit;
  logic             resyncn_d, busy_d, locked_d, fail_d;

  assign retry_cnt = retry_q;
  assign lost      = lost_q;

  // Hunt window and activity run length as they will be after this cycle's sample.
  always_comb begin
    shift_d = {shift_q[PRE_W-2:0], sig_out};
    valid_d = (valid_q == VAL_FULL) ? valid_q : valid_q + 1'b1;
    match   = (valid_d == VAL_FULL) && (shift_d == PREAMBLE);
    if (sig_out != prev_q)
      run_d = CNT_W'(1);
    else
      run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
    run_hit = (run_d == RUN_MAX);
  end

  // State, timers, datapath and registered outputs.
  always_ff @(posedge AXI_clk or posedge AXI_rst) begin
    if (AXI_rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      run_q   <= '0;
      shift_q <= '0;
      valid_q <= '0;
      prev_q  <= 1'b0;
      retry_q <= '0;
      lost_q  <= 1'b0;
      resyncn <= 1'b1;
      busy    <= 1'b0;
      locked  <= 1'b0;
      fail    <= 1'b0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      lost_q  <= lost_d;
      resyncn <= resyncn_d;
      busy    <= busy_d;
      locked  <= locked_d;
      fail    <= fail_d;

      if (state_d != state_q)
        timer_q <= '0;
      else if (state_q == ST_PULSE || state_q == ST_SETTLE || state_q == ST_HUNT)
        timer_q <= timer_q + 1'b1;

      if (state_q == ST_SETTLE) begin
        shift_q <= '0;
        valid_q <= '0;
      end else if (state_q == ST_HUNT) begin
        shift_q <= shift_d;
        valid_q <= valid_d;
      end

      // The sample that completed the preamble seeds the run, so LOCKED starts at run=1.
      if (state_d == ST_LOCKED && state_q != ST_LOCKED) begin
        prev_q <= sig_out;
        run_q  <= CNT_W'(1);
      end else if (state_q == ST_LOCKED) begin
        prev_q <= sig_out;
        run_q  <= run_d;
      end
    end
  end

  // Next state: abort beats start, start beats timers, match beats timeout.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lost_d  = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else if (start && (state_q inside {ST_IDLE, ST_HUNT, ST_LOCKED, ST_FAIL})) begin
      state_d = ST_PULSE;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_PULSE:  if (timer_q == PULSE_END)  state_d = ST_SETTLE;
        ST_SETTLE: if (timer_q == SETTLE_END) state_d = ST_HUNT;
        ST_HUNT: begin
          if (match) begin
            state_d = ST_LOCKED;
          end else if (timer_q == HUNT_END) begin
            if (retry_q == RETRY_LIM) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_PULSE;
              retry_d = retry_q + 4'd1;
            end
          end
        end
        ST_LOCKED: begin
          // lost is shown for one LOCKED cycle before the exit it announces.
          if (lost_q) begin
            if (auto_en) begin
              state_d = ST_PULSE;
              retry_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (run_hit) begin
            lost_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output values for the state being entered, registered with the state.
  always_comb begin
    resyncn_d = (state_d != ST_PULSE);
    busy_d    = (state_d == ST_PULSE) || (state_d == ST_SETTLE) || (state_d == ST_HUNT);
    locked_d  = (state_d == ST_LOCKED);
    fail_d    = (state_d == ST_FAIL);
  end

endmodule

// File: tb/tb_sig_sync_ctrl.sv
// tb/tb_sig_sync_ctrl.sv - directed and randomized bench for sig_sync_ctrl
module tb_sig_sync_ctrl;

  localparam int PULSE_LEN    = 4;
  localparam int SETTLE_LEN   = 32;
  localparam int PRE_W        = 16;
  localparam int PREAMBLE     = 16'hA5F0;
  localparam int HUNT_TIMEOUT = 4096;
  localparam int MAX_RETRY    = 3;
  localparam int MAX_RUN      = 1024;
  localparam int ATTEMPT      = PULSE_LEN + SETTLE_LEN + HUNT_TIMEOUT;
  localparam int HUNT_AT      = 1 + PULSE_LEN + SETTLE_LEN;

  localparam int P_IDLE = 0, P_PULSE = 1, P_SETTLE = 2, P_HUNT = 3, P_LOCKED = 4, P_FAIL = 5;

  logic       AXI_clk = 1'b0;
  logic       AXI_rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0, auto_en = 1'b0, sig_out = 1'b0;
  logic       resyncn, busy, locked, fail, lost;
  logic [3:0] retry_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int n_prints = 0;
  bit chk_en   = 1'b0;
  logic [15:0] pre = 16'(PREAMBLE);

  sig_sync_ctrl dut (
    .AXI_clk(AXI_clk), .AXI_rst(AXI_rst), .start(start), .abort(abort),
    .auto_en(auto_en), .sig_out(sig_out), .resyncn(resyncn), .busy(busy),
    .locked(locked), .fail(fail), .lost(lost), .retry_cnt(retry_cnt)
  );

  always #5 AXI_clk = ~AXI_clk;

  // Behavioural model: phase, cycles spent in it, last PRE_W hunt samples, run length.
  int m_ph    = P_IDLE;
  int m_spent = 0;
  int m_run   = 0;
  int m_retry = 0;
  bit m_prev  = 1'b0;
  bit m_lost  = 1'b0;
  bit m_win[$];

  task automatic go_pulse();
    m_ph    = P_PULSE;
    m_spent = 0;
  endtask

  task automatic model_step(input bit st, input bit ab, input bit au, input bit s);
    bit was_lost;
    int w;
    was_lost = m_lost;
    m_lost   = 1'b0;
    if (ab) begin
      m_ph = P_IDLE;
    end else if (st && (m_ph == P_IDLE || m_ph == P_HUNT || m_ph == P_LOCKED || m_ph == P_FAIL)) begin
      go_pulse();
      m_retry = 0;
    end else begin
      case (m_ph)
        P_PULSE: begin
          m_spent++;
          if (m_spent == PULSE_LEN) begin m_ph = P_SETTLE; m_spent = 0; end
        end
        P_SETTLE: begin
          m_spent++;
          if (m_spent == SETTLE_LEN) begin m_ph = P_HUNT; m_spent = 0; m_win.delete(); end
        end
        P_HUNT: begin
          m_win.push_back(s);
          if (m_win.size() > PRE_W) void'(m_win.pop_front());
          m_spent++;
          w = 0;
          foreach (m_win[i]) w = (w << 1) | int'(m_win[i]);
          if (m_win.size() == PRE_W && w == PREAMBLE) begin
            m_ph = P_LOCKED; m_run = 1; m_prev = s;
          end else if (m_spent == HUNT_TIMEOUT) begin
            if (m_retry == MAX_RETRY) m_ph = P_FAIL;
            else begin m_retry++; go_pulse(); end
          end
        end
        P_LOCKED: begin
          if (was_lost) begin
            if (au) begin go_pulse(); m_retry = 0; end
            else m_ph = P_IDLE;
          end else begin
            m_run  = (s == m_prev) ? m_run + 1 : 1;
            m_prev = s;
            if (m_run == MAX_RUN) m_lost = 1'b1;
          end
        end
        default: ;
      endcase
    end
  endtask

  // Model advances on the same edge as the DUT, with the same async reset.
  always @(posedge AXI_clk or posedge AXI_rst) begin
    if (AXI_rst) begin
      m_ph = P_IDLE; m_spent = 0; m_run = 0; m_retry = 0; m_prev = 1'b0; m_lost = 1'b0;
      m_win.delete();
    end else begin
      model_step(start, abort, auto_en, sig_out);
    end
  end

  // Every-cycle compare of all outputs against the model.
  always @(negedge AXI_clk) begin
    logic [8:0] got, exp;
    if (chk_en) begin
      got = {resyncn, busy, locked, fail, lost, retry_cnt};
      exp = {m_ph != P_PULSE, m_ph == P_PULSE || m_ph == P_SETTLE || m_ph == P_HUNT,
             m_ph == P_LOCKED, m_ph == P_FAIL, m_lost, 4'(m_retry)};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        if (n_prints < 20) begin
          n_prints++;
          $display("FAIL model_cmp t=%0t got rs/bz/lk/fl/lo/rc=%b expected %b", $time, got, exp);
        end
      end
    end
  end

  task automatic check_val(input string name, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== 32'(exp)) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge AXI_clk);
  endtask

  // Start a sequence and feed the preamble from HUNT cycle 'offset'; stops once locked.
  task automatic do_lock(input int offset, output int low, output int bsy, output int idx);
    int h;
    sig_out = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    low = 0; bsy = 0; idx = -1;
    for (int i = 1; i <= HUNT_AT + offset + PRE_W + 4 && idx < 0; i++) begin
      if (i > 1) tick();
      if (!resyncn) low++;
      if (busy) bsy++;
      if (locked) idx = i;
      h = i - HUNT_AT;
      if (h >= offset && h < offset + PRE_W) sig_out = pre[PRE_W - 1 - (h - offset)];
      else sig_out = 1'b0;
    end
  endtask

  task automatic wait_lost(output int k);
    k = -1;
    for (int i = 1; i <= MAX_RUN + 80 && k < 0; i++) begin
      tick();
      if (lost) k = i;
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    int low, bsy, idx, k, falls, fidx, seg, len;
    bit prev_rn, b;
    int fall_at[$];

    tick();
    tick();
    check_val("rst_resyncn", resyncn, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_locked", locked, 0);
    check_val("rst_fail", fail, 0);
    check_val("rst_lost", lost, 0);
    check_val("rst_retry", retry_cnt, 0);
    chk_en  = 1'b1;
    AXI_rst = 1'b0;
    tick();

    // Asynchronous reset in the middle of the resync pulse.
    start = 1'b1; tick(); start = 1'b0; tick();
    check_val("midpulse_resyncn_low", resyncn, 0);
    #2 AXI_rst = 1'b1;
    #1;
    check_val("async_rst_resyncn", resyncn, 1);
    check_val("async_rst_busy", busy, 0);
    check_val("async_rst_retry", retry_cnt, 0);
    tick();
    AXI_rst = 1'b0;
    tick();

    // Clean lock with the preamble 10 cycles into HUNT.
    do_lock(10, low, bsy, idx);
    check_val("lock_low_cycles", low, PULSE_LEN);
    check_val("lock_busy_cycles", bsy, 62);
    check_val("lock_cycle", idx, 63);
    check_val("lock_retry", retry_cnt, 0);
    do_abort();
    tick();

    // No preamble at all: four attempts then FAIL.
    sig_out = 1'b0; start = 1'b1; tick(); start = 1'b0;
    falls = 0; fidx = -1; prev_rn = 1'b1;
    for (int i = 1; i <= 4 * ATTEMPT + 40 && fidx < 0; i++) begin
      if (i > 1) tick();
      if (!resyncn && prev_rn) begin falls++; fall_at.push_back(i); end
      prev_rn = resyncn;
      if (fail) fidx = i;
    end
    check_val("fail_pulses", falls, MAX_RETRY + 1);
    check_val("fail_cycle", fidx, 1 + 4 * ATTEMPT);
    check_val("fail_retry", retry_cnt, 3);
    for (int i = 1; i < fall_at.size(); i++)
      check_val("retry_spacing", fall_at[i] - fall_at[i-1], ATTEMPT);
    start = 1'b1; tick(); start = 1'b0;
    check_val("restart_from_fail_retry", retry_cnt, 0);
    check_val("restart_from_fail_resyncn", resyncn, 0);
    do_abort();

    // Loss of activity with auto resync enabled.
    auto_en = 1'b1;
    do_lock(10, low, bsy, idx);
    sig_out = 1'b1;
    wait_lost(k);
    check_val("lost_auto_cycle", k, MAX_RUN);
    tick();
    check_val("lost_auto_resyncn", resyncn, 0);
    check_val("lost_auto_retry", retry_cnt, 0);
    check_val("lost_single_pulse", lost, 0);
    do_abort();

    // Loss of activity without auto resync returns to IDLE.
    auto_en = 1'b0;
    do_lock(10, low, bsy, idx);
    sig_out = 1'b1;
    wait_lost(k);
    check_val("lost_idle_cycle", k, MAX_RUN);
    tick();
    check_val("lost_idle_busy", busy, 0);
    check_val("lost_idle_locked", locked, 0);
    low = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (!resyncn) low++; end
    check_val("lost_idle_no_pulse", low, 0);

    // start and abort together during HUNT.
    sig_out = 1'b0; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < HUNT_AT + 5; i++) tick();
    check_val("hunt_busy_before_abort", busy, 1);
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check_val("start_abort_busy", busy, 0);
    low = 0;
    for (int i = 0; i < 6; i++) begin if (!resyncn) low++; tick(); end
    check_val("start_abort_resyncn", low, 0);

    // Preamble completes on the timeout cycle: match wins.
    do_lock(HUNT_TIMEOUT - PRE_W, low, bsy, idx);
    check_val("edge_lock_cycle", idx, HUNT_AT + HUNT_TIMEOUT);
    check_val("edge_low_cycles", low, PULSE_LEN);
    check_val("edge_busy_cycles", bsy, ATTEMPT);
    check_val("edge_retry", retry_cnt, 0);
    do_abort();

    // Randomized traffic checked by the model on every cycle.
    for (int c = 0; c < 25000; ) begin
      seg = $urandom_range(0, 9);
      len = (seg < 4) ? $urandom_range(20, 150) : (seg < 7) ? PRE_W : $urandom_range(100, 1300);
      b = 1'($urandom_range(0, 1));
      for (int j = 0; j < len; j++) begin
        if (seg < 4) sig_out = 1'($urandom_range(0, 1));
        else if (seg < 7) sig_out = pre[PRE_W - 1 - j];
        else sig_out = b;
        start = ($urandom_range(0, 2999) == 0);
        abort = ($urandom_range(0, 7999) == 0);
        if ($urandom_range(0, 499) == 0) auto_en = ~auto_en;
        tick();
        c++;
      end
    end
    start = 1'b0; abort = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
